// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard sequencer: FSM states and the bundle
// of stage-control strobes with its canonical settings.
package pipe_hazard_ctrl_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } phc_state_e;

  typedef struct packed {
    logic pc_we;
    logic ifid_we;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_we;
    logic redirect_valid;
  } ctrl_t;

  // Field order: pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, redirect_valid
  localparam ctrl_t CTRL_HOLD     = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
  localparam ctrl_t CTRL_RESET    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
  localparam ctrl_t CTRL_RUN      = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  localparam ctrl_t CTRL_BUBBLE   = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
  localparam ctrl_t CTRL_REDIRECT = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// Load-use hazard compare: a load in EX whose destination is read by the
// instruction currently in ID.
module hazard_detect #(
  parameter int REG_W = 5
) (
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  output logic             load_use
);

  logic rs1_hit;
  logic rs2_hit;

  // x0 is hardwired to zero, so a load targeting it never creates a hazard.
  assign rs1_hit  = id_use_rs1 && (id_rs1 == ex_rd);
  assign rs2_hit  = id_use_rs2 && (id_rs2 == ex_rd);
  assign load_use = ex_valid && ex_memread && (ex_rd != '0) && (rs1_hit || rs2_hit);

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencer: stalls, flushes and PC redirects for the 5-stage core,
// with saturating stall/flush performance counters.
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int REG_W = 5,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [REG_W-1:0] id_rs1,
  input  logic [REG_W-1:0] id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic             ex_memread,
  input  logic [REG_W-1:0] ex_rd,
  input  logic             ex_br_taken,
  input  logic             ex_jump,
  input  logic [XLEN-1:0]  ex_target,
  input  logic             dmem_req,
  input  logic             dmem_ready,
  output logic             pc_we,
  output logic             ifid_we,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_we,
  output logic             redirect_valid,
  output logic [XLEN-1:0]  redirect_pc,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  phc_state_e      state, state_next;
  logic            pend_valid;
  logic [XLEN-1:0] pend_pc;
  ctrl_t           ctrl;
  logic            taken, mem_stall, load_use;
  logic            latch_pend, clear_pend, count_flush;

  assign taken     = ex_valid && (ex_br_taken || ex_jump);
  assign mem_stall = dmem_req && !dmem_ready;

  hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .ex_valid   (ex_valid),
    .ex_memread (ex_memread),
    .ex_rd      (ex_rd),
    .id_rs1     (id_rs1),
    .id_rs2     (id_rs2),
    .id_use_rs1 (id_use_rs1),
    .id_use_rs2 (id_use_rs2),
    .load_use   (load_use)
  );

  always_comb begin
    // NOTE: every output gets a default first so no path leaves one unassigned (no latches).
    ctrl        = CTRL_HOLD;
    redirect_pc = '0;
    state_next  = state;
    latch_pend  = 1'b0;
    clear_pend  = 1'b0;
    count_flush = 1'b0;
    if (rst) begin
      ctrl = CTRL_RESET;
    end else if (mem_stall) begin
      // EX is frozen while memory stalls; remember a branch seen now for the release cycle.
      state_next = MEM_WAIT;
      latch_pend = taken && !pend_valid;
    end else begin
      state_next = RUN;
      if (state == MEM_WAIT && pend_valid) begin
        ctrl        = CTRL_REDIRECT;
        redirect_pc = pend_pc;
        count_flush = 1'b1;
        clear_pend  = 1'b1;
      end else if (taken) begin
        ctrl        = CTRL_REDIRECT;
        redirect_pc = ex_target;
        count_flush = 1'b1;
      end else if (load_use) begin
        ctrl = CTRL_BUBBLE;
      end else begin
        ctrl = CTRL_RUN;
      end
    end
  end

  assign pc_we          = ctrl.pc_we;
  assign ifid_we        = ctrl.ifid_we;
  assign ifid_flush     = ctrl.ifid_flush;
  assign idex_flush     = ctrl.idex_flush;
  assign exmem_we       = ctrl.exmem_we;
  assign redirect_valid = ctrl.redirect_valid;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      pend_valid   <= 1'b0;
      pend_pc      <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      state <= state_next;
      if (latch_pend) begin
        pend_valid <= 1'b1;
        pend_pc    <= ex_target;
      end else if (clear_pend) begin
        pend_valid <= 1'b0;
      end
      if (!ctrl.pc_we && stall_cycles != '1)
        stall_cycles <= stall_cycles + CNT_ONE;
      if (count_flush && flush_events != '1)
        flush_events <= flush_events + CNT_ONE;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed scenarios followed by
// random traffic, all compared against a cycle-level reference model.
module tb_pipe_hazard_ctrl;

  localparam int XLEN  = 32;
  localparam int REG_W = 5;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst;
  logic [REG_W-1:0] id_rs1, id_rs2, ex_rd;
  logic             id_use_rs1, id_use_rs2;
  logic             ex_valid, ex_memread, ex_br_taken, ex_jump;
  logic [XLEN-1:0]  ex_target;
  logic             dmem_req, dmem_ready;
  logic             pc_we, ifid_we, ifid_flush, idex_flush, exmem_we, redirect_valid;
  logic [XLEN-1:0]  redirect_pc;
  logic [CNT_W-1:0] stall_cycles, flush_events;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: waiting on memory, a remembered redirect, counters.
  bit              m_wait;
  bit              m_pend;
  logic [XLEN-1:0] m_pend_pc;
  int              m_stall;
  int              m_flush;

  pipe_hazard_ctrl #(.XLEN(XLEN), .REG_W(REG_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_use_rs1     (id_use_rs1),
    .id_use_rs2     (id_use_rs2),
    .ex_valid       (ex_valid),
    .ex_memread     (ex_memread),
    .ex_rd          (ex_rd),
    .ex_br_taken    (ex_br_taken),
    .ex_jump        (ex_jump),
    .ex_target      (ex_target),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_we          (pc_we),
    .ifid_we        (ifid_we),
    .ifid_flush     (ifid_flush),
    .idex_flush     (idex_flush),
    .exmem_we       (exmem_we),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    rst = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_memread = 1'b0; ex_rd = '0; ex_br_taken = 1'b0; ex_jump = 1'b0;
    ex_target = '0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  // Evaluate one cycle: compare DUT outputs with the model, then advance both across the edge.
  task automatic step();
    bit tk, ms, lu, redir;
    bit e_pc, e_ifid, e_iff, e_idf, e_ex, e_rv;
    logic [XLEN-1:0] e_rpc;
    bit n_wait, n_pend;
    logic [XLEN-1:0] n_pend_pc;
    int n_stall, n_flush;

    #2;
    tk = ex_valid && (ex_br_taken || ex_jump);
    ms = dmem_req && !dmem_ready;
    lu = ex_valid && ex_memread && ex_rd != 0 &&
         ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
    {e_pc, e_ifid, e_iff, e_idf, e_ex, e_rv} = 6'b0;
    e_rpc = '0;
    redir = 1'b0;
    n_wait = m_wait; n_pend = m_pend; n_pend_pc = m_pend_pc;
    n_stall = m_stall; n_flush = m_flush;

    if (rst) begin
      e_iff = 1'b1; e_idf = 1'b1;
      n_wait = 1'b0; n_pend = 1'b0; n_pend_pc = '0; n_stall = 0; n_flush = 0;
    end else begin
      if (ms) begin
        n_wait = 1'b1;
        if (tk && !m_pend) begin n_pend = 1'b1; n_pend_pc = ex_target; end
      end else begin
        n_wait = 1'b0;
        if (m_wait && m_pend) begin
          redir = 1'b1; e_rpc = m_pend_pc; n_pend = 1'b0;
        end else if (tk) begin
          redir = 1'b1; e_rpc = ex_target;
        end else if (lu) begin
          e_idf = 1'b1; e_ex = 1'b1;
        end else begin
          e_pc = 1'b1; e_ifid = 1'b1; e_ex = 1'b1;
        end
      end
      if (redir) begin
        {e_pc, e_ifid, e_iff, e_idf, e_ex, e_rv} = 6'b111111;
        if (n_flush < CMAX) n_flush++;
      end
      if (!e_pc && n_stall < CMAX) n_stall++;
    end

    check("pc_we", pc_we, e_pc);
    check("ifid_we", ifid_we, e_ifid);
    check("ifid_flush", ifid_flush, e_iff);
    check("idex_flush", idex_flush, e_idf);
    check("exmem_we", exmem_we, e_ex);
    check("redirect_valid", redirect_valid, e_rv);
    check("redirect_pc", redirect_pc, e_rpc);
    check("stall_cycles", stall_cycles, m_stall);
    check("flush_events", flush_events, m_flush);

    @(posedge clk);
    m_wait = n_wait; m_pend = n_pend; m_pend_pc = n_pend_pc;
    m_stall = n_stall; m_flush = n_flush;
    #1;
  endtask

  initial begin
    idle_inputs();
    rst = 1'b1;
    @(posedge clk);
    m_wait = 1'b0; m_pend = 1'b0; m_pend_pc = '0; m_stall = 0; m_flush = 0;
    #1;
    step();  // reset still held: override outputs checked
    rst = 1'b0;

    // Taken branch redirects in the same cycle.
    ex_valid = 1'b1; ex_br_taken = 1'b1; ex_target = 32'h40;
    #1;
    check("t1_redirect_pc", redirect_pc, 32'h40);
    check("t1_redirect_valid", redirect_valid, 1'b1);
    step();
    check("t1_flush_events", flush_events, 1);
    idle_inputs(); step();

    // Load-use: one bubble, then x0 destination never stalls.
    ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_use_rs2 = 1'b1;
    #1;
    check("t2_pc_we", pc_we, 1'b0);
    check("t2_idex_flush", idex_flush, 1'b1);
    step();
    check("t2_stall_cycles", stall_cycles, 1);
    idle_inputs(); step();
    ex_valid = 1'b1; ex_memread = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    #1;
    check("t2_x0_pc_we", pc_we, 1'b1);
    step();

    // Memory wait with a branch pending: redirect only on release, once.
    idle_inputs();
    dmem_req = 1'b1; ex_valid = 1'b1; ex_br_taken = 1'b1; ex_target = 32'h80;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("t3_wait_redirect", redirect_valid, 1'b0);
      step();
    end
    dmem_ready = 1'b1; ex_target = 32'h1234;
    #1;
    check("t3_release_pc", redirect_pc, 32'h80);
    step();
    idle_inputs();
    #1;
    check("t3_once", redirect_valid, 1'b0);
    step();

    // Taken and load-use together: redirect wins, no bubble.
    ex_valid = 1'b1; ex_jump = 1'b1; ex_target = 32'h100;
    ex_memread = 1'b1; ex_rd = 5'd7; id_rs1 = 5'd7; id_use_rs1 = 1'b1;
    #1;
    check("t4_pc_we", pc_we, 1'b1);
    step();
    idle_inputs(); step();

    // Reset during a pending redirect discards it.
    dmem_req = 1'b1; ex_valid = 1'b1; ex_br_taken = 1'b1; ex_target = 32'hC0;
    step(); step();
    rst = 1'b1; step();
    idle_inputs();
    #1;
    check("t5_no_redirect", redirect_valid, 1'b0);
    check("t5_stall_zero", stall_cycles, 0);
    step();

    // Long memory stall saturates stall_cycles.
    dmem_req = 1'b1;
    for (int i = 0; i < CMAX + 40; i++) step();
    check("t6_saturated", stall_cycles, CMAX);
    step();
    check("t6_no_wrap", stall_cycles, CMAX);
    idle_inputs(); step();

    // Random traffic; small register range keeps hazards frequent.
    for (int i = 0; i < 3000; i++) begin
      rst         = ($urandom_range(0, 199) == 0);
      id_rs1      = REG_W'($urandom_range(0, 3));
      id_rs2      = REG_W'($urandom_range(0, 3));
      id_use_rs1  = 1'($urandom);
      id_use_rs2  = 1'($urandom);
      ex_valid    = ($urandom_range(0, 3) != 0);
      ex_memread  = 1'($urandom);
      ex_rd       = REG_W'($urandom_range(0, 3));
      ex_br_taken = ($urandom_range(0, 4) == 0);
      ex_jump     = ($urandom_range(0, 9) == 0);
      ex_target   = $urandom;
      dmem_req    = ($urandom_range(0, 2) == 0);
      dmem_ready  = 1'($urandom);
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
